// File: rtl/ipm_mult_seq.sv
// Sequential IPM multiplier over GF(2^8) (poly 0x11B).
// One L_hat row per cycle: delta rows, fix-up, then beta rows.
module ipm_mult_seq #(
   parameter int v = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [(v*v-1)*8-1:0] rand_bits,
   input  logic [v*8-1:0]       R,
   input  logic [v*8-1:0]       Q,
   input  logic [v*v*8-1:0]     L_hat,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [v*8-1:0]       T,
   output logic                 out_err
);

   localparam int RW = (v > 1) ? $clog2(v) : 1;

   typedef enum logic [2:0] {
      IDLE,
      DELTA,
      FIX,
      BETA,
      DONE
   } state_t;

   state_t state, state_n;

   logic [RW-1:0]    row;
   logic             last_row;
   logic [v*v*8-1:0] rnd_q;
   logic [v*v*8-1:0] l_q;
   logic [v*8-1:0]   r_q;
   logic [v*8-1:0]   q_q;
   logic [7:0]       b_m [v][v];
   logic [7:0]       a_m [v][v];
   logic [7:0]       l_m [v][v];
   logic [7:0]       rq_row [v];
   logic [7:0]       delta;
   logic [7:0]       beta;
   logic [7:0]       beta_n;
   logic [7:0]       d_row;
   logic [7:0]       b_row;
   logic [7:0]       a_last;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // x^254 = x^2 * x^4 * ... * x^128; yields 0 for x = 0
   function automatic logic [7:0] inv8(input logic [7:0] a);
      logic [7:0] s;
      logic [7:0] p;
      s = a;
      p = 8'h01;
      for (int k = 1; k < 8; k++) begin
         s = gmul(s, s);
         p = gmul(p, s);
      end
      return p;
   endfunction

   // top byte of rnd_q is zero, so A[v-1][v-1] reads as 0 until the fix-up
   always_comb begin
      for (int i = 0; i < v; i++) begin
         for (int j = 0; j < v; j++) begin
            l_m[i][j] = l_q[(i*v+j)*8 +: 8];
            a_m[i][j] = rnd_q[(i*v+j)*8 +: 8];
         end
      end
   end

   assign last_row = (row == RW'(v-1));

   always_comb begin
      d_row = 8'h00;
      b_row = 8'h00;
      for (int j = 0; j < v; j++) begin
         rq_row[j] = gmul(r_q[row*8 +: 8], q_q[j*8 +: 8]) ^ a_m[row][j];
         if (row == '0 && j == 0)
            d_row = d_row ^ a_m[0][0];
         else
            d_row = d_row ^ gmul(a_m[row][j], l_m[row][j]);
         b_row = b_row ^ gmul(l_m[row][j], b_m[row][j]);
      end
   end

   assign a_last   = gmul(inv8(l_m[v-1][v-1]), delta);
   assign beta_n   = beta ^ b_row;
   assign in_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (in_valid)  state_n = DELTA;
         DELTA:   if (last_row)  state_n = FIX;
         FIX:                    state_n = BETA;
         BETA:    if (last_row)  state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row       <= '0;
         rnd_q     <= '0;
         l_q       <= '0;
         r_q       <= '0;
         q_q       <= '0;
         delta     <= 8'h00;
         beta      <= 8'h00;
         T         <= '0;
         out_err   <= 1'b0;
         out_valid <= 1'b0;
         for (int i = 0; i < v; i++)
            for (int j = 0; j < v; j++)
               b_m[i][j] <= 8'h00;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  rnd_q <= {8'h00, rand_bits};
                  l_q   <= L_hat;
                  r_q   <= R;
                  q_q   <= Q;
                  delta <= 8'h00;
                  row   <= '0;
               end
            end
            DELTA: begin
               delta <= delta ^ d_row;
               for (int j = 0; j < v; j++)
                  b_m[row][j] <= rq_row[j];
               row <= row + RW'(1);
            end
            FIX: begin
               b_m[v-1][v-1] <= b_m[v-1][v-1] ^ a_last;
               out_err       <= (l_m[v-1][v-1] == 8'h00);
               beta          <= b_m[0][0];
               for (int j = 1; j < v; j++)
                  T[j*8 +: 8] <= b_m[0][j];
               row <= RW'(1);
            end
            BETA: begin
               beta <= beta_n;
               row  <= row + RW'(1);
               if (last_row) begin
                  T[7:0]    <= beta_n;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ipm_mult_seq.sv
// Bench for ipm_mult_seq: v=2 directed, v=4 random/back-pressure/abort,
// v=16 random, all against an independent combinational model.
module tb_ipm_mult_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          iv   [3];
   logic          ir   [3];
   logic          ov   [3];
   logic          ordy [3];
   logic          oerr [3];
   logic [2039:0] rnd_w;
   logic [2047:0] l_w;
   logic [127:0]  r_w;
   logic [127:0]  q_w;
   logic [15:0]   t2;
   logic [31:0]   t4;
   logic [127:0]  t16;

   int passed = 0;
   int total  = 0;

   ipm_mult_seq #(.v(2)) u_v2 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .rand_bits(rnd_w[23:0]), .R(r_w[15:0]), .Q(q_w[15:0]),
      .L_hat(l_w[31:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .T(t2), .out_err(oerr[0]));

   ipm_mult_seq #(.v(4)) u_v4 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .rand_bits(rnd_w[119:0]), .R(r_w[31:0]), .Q(q_w[31:0]),
      .L_hat(l_w[127:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .T(t4), .out_err(oerr[1]));

   ipm_mult_seq #(.v(16)) u_v16 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .rand_bits(rnd_w), .R(r_w), .Q(q_w),
      .L_hat(l_w), .out_valid(ov[2]), .out_ready(ordy[2]),
      .T(t16), .out_err(oerr[2]));

   function automatic logic [127:0] get_t(input int sel);
      if (sel == 0) return {112'h0, t2};
      if (sel == 1) return {96'h0, t4};
      return t16;
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] x);
      for (int y = 1; y < 256; y++)
         if (gm(x, 8'(y)) == 8'h01) return 8'(y);
      return 8'h00;
   endfunction

   function automatic void golden(input int vv, input logic [2039:0] rnd,
                                  input logic [2047:0] l,
                                  input logic [127:0] r, input logic [127:0] q,
                                  output logic [127:0] t, output logic err);
      logic [7:0] a  [16][16];
      logic [7:0] b  [16][16];
      logic [7:0] lm [16][16];
      logic [7:0] d;
      logic [7:0] acc;
      int last;
      last = vv - 1;
      for (int i = 0; i < vv; i++)
         for (int j = 0; j < vv; j++) begin
            lm[i][j] = l[(i*vv+j)*8 +: 8];
            if (i == last && j == last) a[i][j] = 8'h00;
            else a[i][j] = rnd[(i*vv+j)*8 +: 8];
         end
      d = a[0][0];
      for (int i = 0; i < vv; i++)
         for (int j = 0; j < vv; j++)
            if (!(i == 0 && j == 0)) d = d ^ gm(a[i][j], lm[i][j]);
      a[last][last] = gm(ginv(lm[last][last]), d);
      for (int i = 0; i < vv; i++)
         for (int j = 0; j < vv; j++)
            b[i][j] = gm(r[i*8 +: 8], q[j*8 +: 8]) ^ a[i][j];
      t = '0;
      for (int j = 1; j < vv; j++) t[j*8 +: 8] = b[0][j];
      acc = b[0][0];
      for (int i = 1; i < vv; i++)
         for (int j = 0; j < vv; j++)
            acc = acc ^ gm(lm[i][j], b[i][j]);
      t[7:0] = acc;
      err = (lm[last][last] == 8'h00);
   endfunction

   function automatic logic [2047:0] rand_vec();
      logic [2047:0] x;
      for (int k = 0; k < 64; k++) x[k*32 +: 32] = $urandom;
      return x;
   endfunction

   // Drives one operation; random in_valid pulses while busy, inputs
   // scrambled after accept, out_ready held low for `hold` cycles.
   task automatic run_op(input int sel, input logic [2039:0] rnd,
                         input logic [2047:0] l, input logic [127:0] r,
                         input logic [127:0] q, input int hold,
                         output logic [127:0] t, output logic err,
                         output int lat, output bit busy_ok,
                         output bit hold_ok, output bit rel_ok);
      rnd_w = rnd;
      l_w = l;
      r_w = r;
      q_w = q;
      iv[sel] = 1'b1;
      @(posedge clk); #1;
      iv[sel] = 1'b0;
      rnd_w = ~rnd;
      l_w = ~l;
      r_w = ~r;
      q_w = ~q;
      lat = 0;
      busy_ok = 1'b1;
      while (!ov[sel] && lat < 200) begin
         if (ir[sel]) busy_ok = 1'b0;
         iv[sel] = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      iv[sel] = 1'b0;
      if (ir[sel]) busy_ok = 1'b0;
      t = get_t(sel);
      err = oerr[sel];
      hold_ok = 1'b1;
      ordy[sel] = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (!ov[sel] || get_t(sel) !== t || oerr[sel] !== err || ir[sel])
            hold_ok = 1'b0;
      end
      ordy[sel] = 1'b1;
      @(posedge clk); #1;
      ordy[sel] = 1'b0;
      rel_ok = (ov[sel] === 1'b0) && (ir[sel] === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         total++;
         if (ir[s] !== 1'b1) $display("FAIL reset_in_ready dut%0d got %b want 1", s, ir[s]);
         else passed++;
         total++;
         if (ov[s] !== 1'b0) $display("FAIL reset_out_valid dut%0d got %b want 0", s, ov[s]);
         else passed++;
         total++;
         if (get_t(s) !== 128'h0) $display("FAIL reset_T dut%0d got %h want 0", s, get_t(s));
         else passed++;
         total++;
         if (oerr[s] !== 1'b0) $display("FAIL reset_out_err dut%0d got %b want 0", s, oerr[s]);
         else passed++;
      end
      rst = 1'b0;
   endtask

   task automatic test_identity();
      logic [127:0] t;
      logic e;
      int lat;
      bit b1, b2, b3;
      run_op(0, 2040'h0, 2048'h01000001, 128'h0001, 128'h0302, 1,
             t, e, lat, b1, b2, b3);
      total++;
      if (t !== 128'h0302) $display("FAIL identity_T got %h want 0302", t);
      else passed++;
      total++;
      if (e !== 1'b0) $display("FAIL identity_err got %b want 0", e);
      else passed++;
      total++;
      if (lat != 4) $display("FAIL identity_latency got %0d want 4", lat);
      else passed++;
      total++;
      if (!(b1 && b2 && b3)) $display("FAIL identity_handshake got %b%b%b want 111", b1, b2, b3);
      else passed++;
   endtask

   task automatic test_fixup();
      logic [127:0] t;
      logic e;
      int lat;
      bit b1, b2, b3;
      run_op(0, 2040'h000001, 2048'h01010101, 128'h0, 128'h0, 0,
             t, e, lat, b1, b2, b3);
      total++;
      if (t !== 128'h0000) $display("FAIL fixup_T got %h want 0000", t);
      else passed++;
      total++;
      if (e !== 1'b0) $display("FAIL fixup_err got %b want 0", e);
      else passed++;
      total++;
      if (lat != 4) $display("FAIL fixup_latency got %0d want 4", lat);
      else passed++;
   endtask

   task automatic test_zero_pivot();
      logic [127:0] t;
      logic e;
      int lat;
      bit b1, b2, b3;
      run_op(0, 2040'h000001, 2048'h00010101, 128'h0, 128'h0, 2,
             t, e, lat, b1, b2, b3);
      total++;
      if (t !== 128'h0001) $display("FAIL zero_pivot_T got %h want 0001", t);
      else passed++;
      total++;
      if (e !== 1'b1) $display("FAIL zero_pivot_err got %b want 1", e);
      else passed++;
      total++;
      if (lat != 4) $display("FAIL zero_pivot_latency got %0d want 4", lat);
      else passed++;
      total++;
      if (!(b1 && b2 && b3)) $display("FAIL zero_pivot_handshake got %b%b%b want 111", b1, b2, b3);
      else passed++;
   endtask

   task automatic rand_op(input int sel, input int vv, input int n);
      logic [2039:0] rnd;
      logic [2047:0] l;
      logic [127:0] r, q, t, exp_t;
      logic e, exp_e;
      int lat, last;
      bit b1, b2, b3;
      last = (vv*vv - 1)*8;
      rnd = 2040'(rand_vec());
      l = rand_vec();
      r = 128'(rand_vec());
      q = 128'(rand_vec());
      if ($urandom_range(0, 7) == 0) l[last +: 8] = 8'h00;
      golden(vv, rnd, l, r, q, exp_t, exp_e);
      run_op(sel, rnd, l, r, q, $urandom_range(0, 3), t, e, lat, b1, b2, b3);
      total++;
      if (t !== exp_t) $display("FAIL rand_T v%0d op%0d got %h want %h", vv, n, t, exp_t);
      else passed++;
      total++;
      if (e !== exp_e) $display("FAIL rand_err v%0d op%0d got %b want %b", vv, n, e, exp_e);
      else passed++;
      total++;
      if (lat != 2*vv) $display("FAIL rand_latency v%0d op%0d got %0d want %0d", vv, n, lat, 2*vv);
      else passed++;
      total++;
      if (!b1) $display("FAIL rand_busy v%0d op%0d got in_ready=1 want 0", vv, n);
      else passed++;
      total++;
      if (!b2) $display("FAIL rand_hold v%0d op%0d got unstable want stable", vv, n);
      else passed++;
      total++;
      if (!b3) $display("FAIL rand_release v%0d op%0d got busy want idle", vv, n);
      else passed++;
   endtask

   task automatic test_random_v4();
      for (int n = 0; n < 1000; n++) rand_op(1, 4, n);
   endtask

   task automatic test_v16();
      for (int n = 0; n < 100; n++) rand_op(2, 16, n);
   endtask

   task automatic test_back_to_back();
      logic [127:0] exp_t;
      logic exp_e;
      int acc_cyc[$];
      int cyc;
      bit pre;
      int w;
      rnd_w = 2040'(rand_vec());
      l_w = rand_vec();
      r_w = 128'(rand_vec());
      q_w = 128'(rand_vec());
      golden(4, rnd_w, l_w, r_w, q_w, exp_t, exp_e);
      iv[1] = 1'b1;
      ordy[1] = 1'b1;
      cyc = 0;
      for (int k = 0; k < 45; k++) begin
         pre = ir[1];
         @(posedge clk); #1;
         cyc++;
         if (pre) acc_cyc.push_back(cyc);
         if (ov[1]) begin
            total++;
            if (get_t(1) !== exp_t) $display("FAIL b2b_T got %h want %h", get_t(1), exp_t);
            else passed++;
         end
      end
      iv[1] = 1'b0;
      w = 0;
      while (!ir[1] && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      ordy[1] = 1'b0;
      total++;
      if (acc_cyc.size() < 4) $display("FAIL b2b_accepts got %0d want >=4", acc_cyc.size());
      else passed++;
      for (int k = 1; k < acc_cyc.size(); k++) begin
         total++;
         if (acc_cyc[k] - acc_cyc[k-1] != 10)
            $display("FAIL b2b_spacing got %0d want 10", acc_cyc[k] - acc_cyc[k-1]);
         else passed++;
      end
   endtask

   task automatic test_abort_v4();
      bit seen;
      rnd_w = 2040'(rand_vec());
      l_w = rand_vec();
      r_w = 128'(rand_vec());
      q_w = 128'(rand_vec());
      iv[1] = 1'b1;
      @(posedge clk); #1;
      rnd_w = ~rnd_w;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         total++;
         if (ir[1] !== 1'b0) $display("FAIL abort_delta_busy got %b want 0", ir[1]);
         else passed++;
      end
      iv[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (ir[1] !== 1'b1) $display("FAIL abort_in_ready got %b want 1", ir[1]);
      else passed++;
      total++;
      if (ov[1] !== 1'b0) $display("FAIL abort_out_valid got %b want 0", ov[1]);
      else passed++;
      total++;
      if (t4 !== 32'h0) $display("FAIL abort_T got %h want 0", t4);
      else passed++;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (ov[1] || !ir[1]) seen = 1'b1;
      end
      total++;
      if (seen) $display("FAIL abort_quiet got activity want idle");
      else passed++;
      rand_op(1, 4, 9999);
   endtask

   initial begin
      rst = 1'b1;
      rnd_w = '0;
      l_w = '0;
      r_w = '0;
      q_w = '0;
      for (int s = 0; s < 3; s++) begin
         iv[s] = 1'b0;
         ordy[s] = 1'b0;
      end
      test_reset();
      test_identity();
      test_fixup();
      test_zero_pivot();
      test_random_v4();
      test_back_to_back();
      test_abort_v4();
      test_v16();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
